// File: rtl/adler32_multibyte_pkg.sv
// Shared constants, state encoding and lane-count helper for the multi-byte Adler-32 engine.
package adler32_pkg;

   localparam logic [15:0] ADLER_MOD = 16'd65521;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Number of contiguous set bits starting at lane 0; anything past the first gap is ignored.
   function automatic logic [3:0] keep_count(input logic [7:0] keep, input int lanes);
      logic [3:0] n;
      logic       stop;
      n    = '0;
      stop = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i < lanes && !stop) begin
            if (keep[i]) n = n + 4'd1;
            else         stop = 1'b1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/adler32_multibyte_if.sv
// Input beat stream and checksum result stream of the Adler-32 engine, with source/engine modports.
interface adler32_multibyte_if #(
   parameter int BPB   = 4,
   parameter int LEN_W = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [8*BPB-1:0]     in_data;
   logic [BPB-1:0]       in_keep;
   logic                 in_last;
   logic                 cks_valid;
   logic                 cks_ready;
   logic [31:0]          cks;
   logic [LEN_W-1:0]     cks_len;

   modport master (
      output in_valid, in_data, in_keep, in_last, cks_ready,
      input  in_ready, cks_valid, cks, cks_len
   );

   modport slave (
      input  in_valid, in_data, in_keep, in_last, cks_ready,
      output in_ready, cks_valid, cks, cks_len
   );
endinterface

// File: rtl/adler32_multibyte_mod_reduce.sv
// Combinational reduction of a 20-bit value modulo 65521 using 2^16 = 15 (mod 65521).
module adler32_mod_reduce
   import adler32_pkg::*;
(
   input  logic [19:0] x,
   output logic [15:0] y
);

   logic [16:0] folded;

   // One fold brings any 20-bit input below 65776, so a single subtract finishes the job.
   always_comb begin
      folded = 17'(x[19:16]) * 17'd15 + 17'(x[15:0]);
      if (folded >= 17'(ADLER_MOD)) y = 16'(folded - 17'(ADLER_MOD));
      else                          y = folded[15:0];
   end

endmodule

// File: rtl/adler32_multibyte.sv
// Streaming Adler-32 engine taking BYTES_PER_BEAT bytes per beat and reporting {B,A} plus byte length.
// Optional ADLER32_SEED_EN adds a seed port giving the {B,A} start value of each message.
module adler32_multibyte
   import adler32_pkg::*;
#(
   parameter int BYTES_PER_BEAT = 4,
   parameter int LEN_W          = 32
) (
   input  logic clock,
   input  logic rst,
`ifdef ADLER32_SEED_EN
   input  logic [31:0] seed,
`endif
   adler32_multibyte_if.slave bus
);

   state_t           state, state_next;
   logic [15:0]      a_reg, b_reg;
   logic [LEN_W-1:0] len_reg;
   logic             accept;
   logic [7:0]       keep_ext;
   logic [3:0]       k;
   logic [15:0]      a_base, b_base;
   logic [19:0]      sum_d, wsum, a_raw, b_raw;
   logic [15:0]      a_new, b_new;

   assign accept        = bus.in_valid && (state != DONE);
   assign bus.in_ready  = (state != DONE);
   assign bus.cks_valid = (state == DONE);
   assign bus.cks       = {b_reg, a_reg};
   assign bus.cks_len   = len_reg;

   // The first beat of a message starts from the seed when seeding is built in.
   always_comb begin
`ifdef ADLER32_SEED_EN
      logic [15:0] seed_a, seed_b;
      seed_a = (seed[15:0]  >= ADLER_MOD) ? seed[15:0]  - ADLER_MOD : seed[15:0];
      seed_b = (seed[31:16] >= ADLER_MOD) ? seed[31:16] - ADLER_MOD : seed[31:16];
      a_base = (state == IDLE) ? seed_a : a_reg;
      b_base = (state == IDLE) ? seed_b : b_reg;
`else
      a_base = a_reg;
      b_base = b_reg;
`endif
   end

   // B advances by k copies of the old A plus each byte weighted by how many later sums it enters.
   always_comb begin
      keep_ext                     = '0;
      keep_ext[BYTES_PER_BEAT-1:0] = bus.in_keep;
      k     = keep_count(keep_ext, BYTES_PER_BEAT);
      sum_d = '0;
      wsum  = '0;
      for (int i = 0; i < BYTES_PER_BEAT; i++) begin
         if (4'(i) < k) begin
            sum_d = sum_d + 20'(bus.in_data[8*i +: 8]);
            wsum  = wsum + 20'(k - 4'(i)) * 20'(bus.in_data[8*i +: 8]);
         end
      end
      a_raw = 20'(a_base) + sum_d;
      b_raw = 20'(b_base) + 20'(k) * 20'(a_base) + wsum;
   end

   adler32_mod_reduce u_reduce_a (.x(a_raw), .y(a_new));
   adler32_mod_reduce u_reduce_b (.x(b_raw), .y(b_new));

   always_ff @(posedge clock) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, RUN: if (accept) state_next = bus.in_last ? DONE : RUN;
         DONE:      if (bus.cks_ready) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Running sums hold through DONE so the result stays put under backpressure.
   always_ff @(posedge clock) begin
      if (rst) begin
         a_reg   <= 16'd1;
         b_reg   <= 16'd0;
         len_reg <= '0;
      end else if (accept) begin
         a_reg   <= a_new;
         b_reg   <= b_new;
         len_reg <= len_reg + LEN_W'(k);
      end else if (state == DONE && bus.cks_ready) begin
         a_reg   <= 16'd1;
         b_reg   <= 16'd0;
         len_reg <= '0;
      end
   end

endmodule

// File: tb/tb_adler32_multibyte.sv
// Directed bench for adler32_multibyte (BPB=4) against a byte-serial Adler-32 model.
module tb_adler32_multibyte;

   typedef logic [7:0] byte_q_t[$];

   logic clock;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
`ifdef ADLER32_SEED_EN
   logic [31:0] seed = 32'h0000_0001;
`endif

   byte_q_t     msg_bytes;
   logic        msg_open = 1'b0;
   logic [31:0] msg_start;
   logic [31:0] exp_cks[$];
   logic [31:0] exp_len[$];

   adler32_multibyte_if #(.BPB(4), .LEN_W(32)) bus ();

   adler32_multibyte #(.BYTES_PER_BEAT(4), .LEN_W(32)) dut (
      .clock(clock),
      .rst(rst),
`ifdef ADLER32_SEED_EN
      .seed(seed),
`endif
      .bus(bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] serial_adler(input byte_q_t q, input logic [31:0] start);
      int unsigned a, b;
      a = start[15:0];
      b = start[31:16];
      if (a >= 65521) a -= 65521;
      if (b >= 65521) b -= 65521;
      foreach (q[i]) begin
         a = (a + q[i]) % 65521;
         b = (b + a) % 65521;
      end
      return {b[15:0], a[15:0]};
   endfunction

   function automatic byte_q_t str_q(input string s);
      byte_q_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   function automatic logic [31:0] pack(input string s);
      logic [31:0] d = '0;
      for (int i = 0; i < s.len(); i++) d[8*i +: 8] = s[i];
      return d;
   endfunction

   task automatic model_accept(input logic [31:0] data, input logic [3:0] keep, input logic last);
      if (!msg_open) begin
`ifdef ADLER32_SEED_EN
         msg_start = seed;
`else
         msg_start = 32'h0000_0001;
`endif
         msg_open = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         if (!keep[i]) break;
         msg_bytes.push_back(data[8*i +: 8]);
      end
      if (last) begin
         exp_cks.push_back(serial_adler(msg_bytes, msg_start));
         exp_len.push_back(32'(msg_bytes.size()));
         msg_bytes.delete();
         msg_open = 1'b0;
      end
   endtask

   // Offers one beat and holds it until the engine takes it; stalls counts refused edges.
   task automatic applyStimulus(input logic [31:0] data, input logic [3:0] keep, input logic last,
                                output int stalls);
      logic ok, accepted;
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      bus.in_keep  = keep;
      bus.in_last  = last;
      stalls   = 0;
      accepted = 1'b0;
      while (!accepted && stalls < 20) begin
         ok = bus.in_ready;
         @(posedge clock);
         #1;
         if (ok) accepted = 1'b1;
         else    stalls++;
      end
      bus.in_valid = 1'b0;
      if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
      else           model_accept(data, keep, last);
   endtask

   task automatic doReset(input int cycles);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      repeat (cycles) @(posedge clock);
      #1;
      rst = 1'b0;
      msg_bytes.delete();
      msg_open = 1'b0;
      exp_cks.delete();
      exp_len.delete();
   endtask

   task automatic checkResult(input string name, input logic [31:0] cks, input logic [31:0] len);
      checkOutput({name, "_valid"}, 32'(bus.cks_valid), 32'd1);
      checkOutput({name, "_cks"}, bus.cks, cks);
      checkOutput({name, "_len"}, bus.cks_len, len);
   endtask

   // Every result transfer is checked against the oldest message the model has closed.
   always @(negedge clock) begin
      if (!rst) begin
         checkOutput("ready_vs_valid", 32'(bus.in_ready), 32'(!bus.cks_valid));
         if (bus.cks_valid && bus.cks_ready) begin
            if (exp_cks.size() == 0) begin
               checkOutput("unexpected_cks_valid", 32'd1, 32'd0);
            end else begin
               checkOutput("model_cks", bus.cks, exp_cks.pop_front());
               checkOutput("model_len", bus.cks_len, exp_len.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      int      st;
      byte_q_t ff_q;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_keep   = '0;
      bus.in_last   = 1'b0;
      bus.cks_ready = 1'b1;

      for (int i = 0; i < 257; i++) ff_q.push_back(8'hFF);
      checkOutput("pin_wikipedia", serial_adler(str_q("Wikipedia"), 32'h1), 32'h11E6_0398);
      checkOutput("pin_abc",       serial_adler(str_q("abc"), 32'h1),       32'h024D_0127);
      checkOutput("pin_a",         serial_adler(str_q("a"), 32'h1),         32'h0062_0062);
      checkOutput("pin_empty",     serial_adler(str_q(""), 32'h1),          32'h0000_0001);
      checkOutput("pin_ff257",     serial_adler(ff_q, 32'h1),               32'h080F_000F);
      checkOutput("pin_seed_a",    serial_adler(str_q("a"), 32'h11E6_0398), 32'h15DF_03F9);
      checkOutput("pin_seed_red",  serial_adler(str_q(""), 32'hFFF1_FFF1),  32'h0000_0000);

      doReset(3);
      checkOutput("reset_in_ready",  32'(bus.in_ready),  32'd1);
      checkOutput("reset_cks_valid", 32'(bus.cks_valid), 32'd0);
      checkOutput("reset_cks",       bus.cks,            32'h0000_0001);
      checkOutput("reset_len",       bus.cks_len,        32'd0);

      $display("[TB] Wikipedia in three beats");
      applyStimulus(pack("Wiki"), 4'b1111, 1'b0, st);
      applyStimulus(pack("pedi"), 4'b1111, 1'b0, st);
      applyStimulus(pack("a"),    4'b0001, 1'b1, st);
      checkResult("wikipedia", 32'h11E6_0398, 32'd9);
      @(posedge clock); #1;

      $display("[TB] abc under backpressure, then empty message");
      bus.cks_ready = 1'b0;
      applyStimulus(pack("abc"), 4'b0111, 1'b1, st);
      checkResult("abc", 32'h024D_0127, 32'd3);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0;
      bus.in_keep  = 4'b0000;
      bus.in_last  = 1'b1;
      repeat (3) begin
         @(posedge clock); #1;
         checkOutput("bp_hold_cks",   bus.cks,            32'h024D_0127);
         checkOutput("bp_hold_len",   bus.cks_len,        32'd3);
         checkOutput("bp_in_ready",   32'(bus.in_ready),  32'd0);
         checkOutput("bp_cks_valid",  32'(bus.cks_valid), 32'd1);
      end
      bus.cks_ready = 1'b1;
      applyStimulus(32'h0, 4'b0000, 1'b1, st);
      checkOutput("bp_stall_cycles", 32'(st), 32'd1);
      checkResult("empty", 32'h0000_0001, 32'd0);
      @(posedge clock); #1;

      $display("[TB] reset mid-message");
      applyStimulus(pack("Wiki"), 4'b1111, 1'b0, st);
      applyStimulus(pack("pedi"), 4'b1111, 1'b0, st);
      doReset(1);
      checkOutput("midrst_cks_valid", 32'(bus.cks_valid), 32'd0);
      checkOutput("midrst_cks",       bus.cks,            32'h0000_0001);
      applyStimulus(pack("a"), 4'b0001, 1'b1, st);
      checkResult("after_reset_a", 32'h0062_0062, 32'd1);
      @(posedge clock); #1;

      $display("[TB] 257 bytes of FF");
      for (int i = 0; i < 64; i++) applyStimulus(32'hFFFF_FFFF, 4'b1111, 1'b0, st);
      applyStimulus(32'hAAAA_AAFF, 4'b0001, 1'b1, st);
      checkResult("ff257", 32'h080F_000F, 32'd257);
      @(posedge clock); #1;

      $display("[TB] partial and gapped keep on non-last beats");
      applyStimulus(pack("ab"), 4'b0011, 1'b0, st);
      applyStimulus(32'h1234_5678, 4'b1110, 1'b0, st);
      applyStimulus({8'h99, 8'h77, 8'h55, 8'h63}, 4'b1101, 1'b1, st);
      checkResult("gapped_abc", 32'h024D_0127, 32'd3);
      @(posedge clock); #1;

`ifdef ADLER32_SEED_EN
      $display("[TB] seeded messages");
      seed = 32'h11E6_0398;
      applyStimulus(pack("a"), 4'b0001, 1'b1, st);
      checkResult("seed_a", 32'h15DF_03F9, 32'd1);
      @(posedge clock); #1;
      seed = 32'hFFF1_FFF1;
      applyStimulus(32'h0, 4'b0000, 1'b1, st);
      checkResult("seed_reduced", 32'h0000_0000, 32'd0);
      @(posedge clock); #1;
`endif

      repeat (3) @(posedge clock);
      #1;
      checkOutput("drain", 32'(exp_cks.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
